// File: rtl/button_gesture_pkg.sv
// Shared types and helpers for the button gesture classifier.
// State encoding and unit-counter sizing live here.
package button_gesture_pkg;

  typedef enum logic [2:0] {
    e_idle     = 3'd0,
    e_press1   = 3'd1,
    e_long     = 3'd2,
    e_release1 = 3'd3,
    e_press2   = 3'd4
  } t_gesture_state;

  function automatic int cnt_width(input int long_ms, input int dclick_ms);
    int m;
    m = (long_ms > dclick_ms) ? long_ms : dclick_ms;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_gesture_fsm_unit_tick_gen.sv
// Prescaler producing a one-cycle unit tick every TICK_PERIOD_10NS cycles.
// A synchronous clear restarts the period so timing is exact from a clear.
module unit_tick_gen #(
  parameter int TICK_PERIOD_10NS = 100_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = $clog2(TICK_PERIOD_10NS);
  localparam logic [PW-1:0] LAST = PW'(TICK_PERIOD_10NS - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_comb begin
    o_tick  = (presc_q == LAST);
    presc_d = presc_q + 1'b1;
    if (i_clr || o_tick) presc_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) presc_q <= '0;
    else       presc_q <= presc_d;
  end

endmodule

// File: rtl/button_gesture_fsm.sv
// Classifies presses into short, long and double-click gestures.
// All outputs are registered one-cycle pulses, plus a held level.
module button_gesture_fsm
  import button_gesture_pkg::*;
#(
  parameter int TICK_PERIOD_10NS = 100_000,
  parameter int LONG_MS          = 800,
  parameter int DCLICK_MS        = 250
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  input  logic i_rise,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_held
);

  localparam int MAX_MS = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
  localparam int CW     = cnt_width(LONG_MS, DCLICK_MS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_MS);
  localparam logic [CW-1:0] LONG_LST = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] DCLK_LST = CW'(DCLICK_MS - 1);

  t_gesture_state state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic double_q, double_d;
  logic held_q, held_d;
  logic unit_tick;
  logic clr;

  unit_tick_gen #(
    .TICK_PERIOD_10NS(TICK_PERIOD_10NS)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (clr),
    .o_tick(unit_tick)
  );

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (i_rise) state_d = e_press1;
      end
      e_press1: begin
        // release beats a coincident threshold tick
        if (!i_level) begin
          state_d = e_release1;
        end else if (unit_tick && cnt_q == LONG_LST) begin
          state_d = e_long;
          long_d  = 1'b1;
        end
      end
      e_long: begin
        if (!i_level) state_d = e_idle;
      end
      e_release1: begin
        if (i_rise) begin
          state_d  = e_press2;
          double_d = 1'b1;
        end else if (unit_tick && cnt_q == DCLK_LST) begin
          state_d = e_idle;
          short_d = 1'b1;
        end
      end
      e_press2: begin
        if (!i_level) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
    held_d = (state_d == e_long);
    clr    = (state_d != state_q);
    cnt_d  = cnt_q;
    if (clr) cnt_d = '0;
    else if (unit_tick && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= e_idle;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

  assign o_short  = short_q;
  assign o_long   = long_q;
  assign o_double = double_q;
  assign o_held   = held_q;

endmodule

// File: tb/tb_button_gesture_fsm.sv
// Scoreboard bench for button_gesture_fsm with a small timing config.
// Expected pulses (cycle, kind) are queued as stimulus is driven.
module tb_button_gesture_fsm;
  import button_gesture_pkg::*;

  localparam int P = 4;
  localparam int L = 10;
  localparam int D = 5;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic level = 1'b0;
  logic rise = 1'b0;
  logic o_short, o_long, o_double, o_held;

  int cyc = 0;
  int nvec = 0;
  int nmis = 0;
  exp_t sb[$];

  button_gesture_fsm #(
    .TICK_PERIOD_10NS(P),
    .LONG_MS(L),
    .DCLICK_MS(D)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_level (level),
    .i_rise  (rise),
    .o_short (o_short),
    .o_long  (o_long),
    .o_double(o_double),
    .o_held  (o_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 short, 1 long, 2 double
  always @(negedge clk) begin
    if (!rst && (o_short || o_long || o_double)) begin
      int k;
      exp_t e;
      k = o_short ? 0 : (o_long ? 1 : 2);
      nvec++;
      if ((int'(o_short) + int'(o_long) + int'(o_double)) != 1) begin
        nmis++;
        $display("FAIL onehot cyc=%0d got s%0b l%0b d%0b need one",
                 cyc, o_short, o_long, o_double);
      end
      nvec++;
      if (sb.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_pulse cyc=%0d got kind %0d need none",
                 cyc, k);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || e.kind !== k) begin
          nmis++;
          $display("FAIL pulse got cyc=%0d kind=%0d need cyc=%0d kind=%0d",
                   cyc, k, e.cyc, e.kind);
        end
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int c, input int k);
    exp_t e;
    e.cyc = c;
    e.kind = k;
    sb.push_back(e);
  endtask

  task automatic press(output int r);
    @(negedge clk);
    r = cyc;
    rise = 1'b1;
    level = 1'b1;
    @(negedge clk);
    rise = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (P * 3) @(negedge clk);
    nvec++;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL %s_missing got %0d pending need 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_held(input string name, input logic exp);
    nvec++;
    if (o_held !== exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d got %0b need %0b", name, cyc, o_held, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if ({o_short, o_long, o_double, o_held} !== 4'b0) begin
      nmis++;
      $display("FAIL reset_outputs got %b need 0000",
               {o_short, o_long, o_double, o_held});
    end
    nvec++;
    if (dut.state_q !== e_idle) begin
      nmis++;
      $display("FAIL reset_state got %0d need %0d", dut.state_q, e_idle);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_short();
    int r;
    press(r);
    push(r + 29, 0);
    at(r + 8);
    level = 1'b0;
    drain("short");
  endtask

  task automatic test_long();
    int r;
    press(r);
    push(r + 41, 1);
    at(r + 40);
    check_held("held_before", 1'b0);
    at(r + 41);
    check_held("held_rise", 1'b1);
    at(r + 50);
    rise = 1'b1;
    @(negedge clk);
    rise = 1'b0;
    at(r + 60);
    check_held("held_hold", 1'b1);
    level = 1'b0;
    at(r + 61);
    check_held("held_drop", 1'b0);
    drain("long");
  endtask

  task automatic test_double();
    int r;
    press(r);
    at(r + 8);
    level = 1'b0;
    at(r + 14);
    push(r + 15, 2);
    rise = 1'b1;
    level = 1'b1;
    @(negedge clk);
    rise = 1'b0;
    at(r + 114);
    level = 1'b0;
    at(r + 116);
    nvec++;
    if (dut.state_q !== e_idle) begin
      nmis++;
      $display("FAIL double_idle got %0d need %0d", dut.state_q, e_idle);
    end
    drain("double");
  endtask

  task automatic test_ties();
    int r;
    press(r);
    at(r + 40);
    level = 1'b0;
    push(r + 61, 0);
    drain("tie_long");
    press(r);
    at(r + 8);
    level = 1'b0;
    at(r + 28);
    push(r + 29, 2);
    rise = 1'b1;
    level = 1'b1;
    @(negedge clk);
    rise = 1'b0;
    at(r + 35);
    level = 1'b0;
    drain("tie_double");
  endtask

  task automatic test_reset_mid();
    int r;
    press(r);
    at(r + 30);
    rst = 1'b1;
    at(r + 31);
    nvec++;
    if ({o_short, o_long, o_double, o_held} !== 4'b0 ||
        dut.state_q !== e_idle) begin
      nmis++;
      $display("FAIL reset_mid got %b st=%0d need 0000 st=0",
               {o_short, o_long, o_double, o_held}, dut.state_q);
    end
    rst = 1'b0;
    at(r + 60);
    level = 1'b0;
    repeat (3) @(negedge clk);
    press(r);
    push(r + 41, 1);
    at(r + 45);
    level = 1'b0;
    drain("reset_fresh");
  endtask

  task automatic test_back_to_back();
    int r;
    int n;
    press(r);
    push(r + 29, 0);
    at(r + 8);
    level = 1'b0;
    n = 0;
    while (!o_short && n < 100) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (!o_short) begin
      nmis++;
      $display("FAIL b2b_short_timeout got 0 need 1");
    end
    press(r);
    push(r + 41, 1);
    at(r + 50);
    level = 1'b0;
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_ties();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1);
  end

endmodule
